fetch_ctrl: RTL

- Fetch-side controller between the PC register and instruction memory.
- Reads the current PC and issues instruction-memory requests with a req/gnt handshake.
- Computes PC_NEXT: hold, +4, or redirect target.
- Buffers returned instructions with their PCs in a small FIFO toward decode, and discards stale responses after a branch/jump redirect.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch controller.
package fetch_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count. Storage is not
// reset; only pointers and count are. Push when full and pop when empty
// are ignored, and flush takes precedence over both.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer/count values; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues in-order instruction-memory requests under a
// credit limit, computes the next PC, buffers returned instructions with
// their PCs for decode, and drops responses made stale by a redirect.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets
// raise a sticky misalign_err_o and stall fetch until an aligned redirect;
// without it the target's low two bits are forced to zero.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              DEPTH        = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output logic            misalign_err_o
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     ibuf_count;
    logic              ibuf_empty;
    logic [2*XLEN-1:0] ibuf_head;
    logic [XLEN-1:0]   inflight_pc;
    logic [XLEN-1:0]   redirect_target;
    logic              credit_ok;
    logic              fetch_block;
    logic              issue;
    logic              rsp;
    logic              ibuf_push;
    logic              ibuf_pop;
    logic [CW-1:0]     unused_inflight_count;
    logic              unused_inflight_empty;

    // Credit covers both in-flight requests and buffered instructions, so a
    // granted response always finds a slot.
    assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, ibuf_count}) < DEPTH_W;
    assign imem_req_o = rst && !redirect_i && !fetch_block && credit_ok;
    assign imem_addr_o = pc_i;
    assign issue      = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is a leftover from before reset.
    assign rsp       = imem_rvalid_i && (outstanding_q != '0);
    assign ibuf_push = rsp && (discard_q == '0) && !redirect_i;
    assign ibuf_pop  = instr_valid_o && instr_ready_i && !redirect_i;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign redirect_target = redirect_pc_i;
    assign fetch_block     = misalign_q;
    assign misalign_err_o  = misalign_q;

    // Sticky misalignment flag, re-evaluated on every redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_i) begin
            misalign_q <= (redirect_pc_i[1:0] != 2'b00);
        end
    end
`else
    logic [1:0] unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc_i[1:0];
    assign redirect_target      = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign fetch_block          = 1'b0;
    assign misalign_err_o       = 1'b0;
`endif

    // Next PC: reset vector, then redirect, then sequential advance, else hold.
    always_comb begin
        pc_next_o = pc_i;
        if (!rst) begin
            pc_next_o = RESET_VECTOR;
        end else if (redirect_i) begin
            pc_next_o = redirect_target;
        end else if (issue) begin
            pc_next_o = pc_i + XLEN'(INSTR_BYTES);
        end
    end

    // Outstanding tracking; a redirect marks everything still in flight as stale.
    always_comb begin
        outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
        discard_d     = discard_q;
        if (redirect_i) begin
            discard_d = outstanding_d;
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
    end

    // Outstanding and discard counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_inflight_q (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (issue),
        .data_i  (pc_i),
        .pop_i   (rsp),
        .flush_i (1'b0),
        .data_o  (inflight_pc),
        .count_o (unused_inflight_count),
        .empty_o (unused_inflight_empty)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_instr_buf (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (ibuf_push),
        .data_i  ({imem_rdata_i, inflight_pc}),
        .pop_i   (ibuf_pop),
        .flush_i (redirect_i),
        .data_o  (ibuf_head),
        .count_o (ibuf_count),
        .empty_o (ibuf_empty)
    );

    assign instr_valid_o = !ibuf_empty;
    assign instr_o       = instr_valid_o ? ibuf_head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
    assign instr_pc_o    = ibuf_head[XLEN-1:0];

endmodule
